// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle for alu_pipe: one request channel, one
// result channel, and the architectural flag register as read-only outputs.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_write;
  logic             illegal;
  logic             zf;
  logic             vf;
  logic             nf;

  modport master (
    output in_valid, opcode, in1, in2, out_ready,
    input  in_ready, out_valid, result, flag_write, illegal, zf, vf, nf
  );

  modport slave (
    input  in_valid, opcode, in1, in2, out_ready,
    output in_ready, out_valid, result, flag_write, illegal, zf, vf, nf
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage ALU: S1 registers the request, S2 registers result plus flag
// update mask; the Z/V/N register commits only when a result is handed off.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input logic     clk,
  input logic     rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int NIB = WIDTH / 4;
  localparam logic [2:0] MASK_ZVN = 3'b111;
  localparam logic [2:0] MASK_Z   = 3'b100;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB
  } op_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  // mask bit order is {Z, V, N}
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             v;
    logic             n;
    logic [2:0]       mask;
    logic             ill;
  } rsp_t;

  logic [2:1] vld_pipe;
  req_t       s1;
  rsp_t       s2;
  rsp_t       nxt;
  logic       adv2;
  logic       zf_q, vf_q, nf_q;

  assign adv2         = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready = !vld_pipe[1] || adv2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (bus.in_ready) vld_pipe[1] <= bus.in_valid;
      if (bus.in_valid && bus.in_ready)
        s1 <= '{op: bus.opcode, a: bus.in1, b: bus.in2};
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2 <= nxt;
      end
    end
  end

  // Saturating add/sub shares one adder: subtract is a + ~b + 1.
  logic             sub;
  logic [WIDTH-1:0] bx, sum, sat, addr, red;
  logic             ovf;
  logic [SHW-1:0]   sh;

  assign sub  = (s1.op == OP_SUB);
  assign bx   = sub ? ~s1.b : s1.b;
  assign sum  = s1.a + bx + WIDTH'(sub);
  assign ovf  = (s1.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != s1.a[WIDTH-1]);
  assign sat  = s1.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign addr = s1.a + s1.b;
  assign sh   = s1.b[SHW-1:0];

  // Sign-extended nibbles of both operands, summed for RED.
  logic [2*NIB-1:0][WIDTH-1:0] nib;

  generate
    for (genvar g = 0; g < NIB; g++) begin : g_nib
      assign nib[g]     = {{(WIDTH-4){s1.a[4*g+3]}}, s1.a[4*g +: 4]};
      assign nib[NIB+g] = {{(WIDTH-4){s1.b[4*g+3]}}, s1.b[4*g +: 4]};
    end
  endgenerate

  always_comb begin
    red = '0;
    for (int i = 0; i < 2*NIB; i++) red = red + nib[i];
  end

  always_comb begin
    nxt = '0;
    case (s1.op)
      OP_ADD, OP_SUB: begin
        nxt.res  = ovf ? sat : sum;
        nxt.v    = ovf;
        nxt.mask = MASK_ZVN;
      end
      OP_XOR: begin
        nxt.res  = s1.a ^ s1.b;
        nxt.mask = MASK_Z;
      end
      OP_RED: nxt.res = red;
      OP_SLL: begin
        nxt.res  = s1.a << sh;
        nxt.mask = MASK_Z;
      end
      OP_SRA: begin
        nxt.res  = $signed(s1.a) >>> sh;
        nxt.mask = MASK_Z;
      end
      OP_ROR: begin
        nxt.res  = WIDTH'({s1.a, s1.a} >> sh);
        nxt.mask = MASK_Z;
      end
      OP_LW, OP_SW: nxt.res = addr;
      OP_LLB:       nxt.res = {s1.a[WIDTH-1:8], s1.b[7:0]};
      OP_LHB:       nxt.res = {s1.b[7:0], s1.a[WIDTH-9:0]};
      default:      nxt.ill = 1'b1;
    endcase
    nxt.z = (nxt.res == '0);
    nxt.n = nxt.res[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q <= 1'b0;
      vf_q <= 1'b0;
      nf_q <= 1'b0;
    end else if (vld_pipe[2] && bus.out_ready) begin
      if (s2.mask[2]) zf_q <= s2.z;
      if (s2.mask[1]) vf_q <= s2.v;
      if (s2.mask[0]) nf_q <= s2.n;
    end
  end

  assign bus.out_valid  = vld_pipe[2];
  assign bus.result     = s2.res;
  assign bus.flag_write = |s2.mask;
  assign bus.illegal    = s2.ill;
  assign bus.zf         = zf_q;
  assign bus.vf         = vf_q;
  assign bus.nf         = nf_q;
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width in bits; legal values are multiples of 8, at least 16.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  asynchronous active-high reset.
REQ-005 Port: in_valid  in  1  operation present on in1/in2/opcode.
REQ-006 Port: in_ready  out  1  block accepts operation this cycle.
REQ-007 Port: opcode  in  4  operation select.
REQ-008 Port: in1, in2  in  WIDTH  operands.
REQ-009 Port: out_valid  out  1  result present.
REQ-010 Port: out_ready  in  1  consumer accepts result this cycle.
REQ-011 Port: result  out  WIDTH  operation result.
REQ-012 Port: flag_write  out  1  result's operation updates the flag register.
REQ-013 Port: illegal  out  1  result came from an unsupported opcode.
REQ-014 Port: zf, vf, nf  out  1 each  flag register (Zero, Overflow, Negative).

Function
REQ-015 Opcodes SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 8 LW-address, 9 SW-address, A LLB, B LHB; 7 and C-F are illegal.
REQ-016 ADD/SUB SHALL be two's-complement, saturating: positive overflow -> 0x7F..F, negative overflow -> 0x80..0, V=1; otherwise exact, V=0.
REQ-017 LW/SW SHALL compute in1+in2 modulo 2^WIDTH, no saturation.
REQ-018 XOR SHALL produce in1^in2.
REQ-019 RED SHALL sum all signed 4-bit nibbles of in1 and in2 and sign-extend the sum to WIDTH.
REQ-020 SLL/SRA/ROR SHALL shift or rotate in1 by in2[log2(WIDTH)-1:0]; SRA sign-fills; ROR rotates right; amount 0 returns in1.
REQ-021 LLB SHALL produce {in1[WIDTH-1:8], in2[7:0]}; LHB SHALL produce {in1[WIDTH-1:WIDTH-8] replaced by in2[7:0], in1[WIDTH-9:0] kept}.
REQ-022 Illegal opcodes SHALL produce result 0, illegal=1, flag_write=0.
REQ-023 Flag masks: ADD/SUB write Z, V, N; XOR/SLL/SRA/ROR write Z only; all others write none; flag_write=1 iff the mask is non-empty.
REQ-024 Z=1 iff result is all zeros; N=result MSB; V per REQ-016.
REQ-025 Pipeline SHALL have two register stages, S1 (operands, opcode) and S2 (result, flags, mask, illegal); throughput one operation per cycle.
REQ-026 An input handshake (in_valid and in_ready) in cycle c SHALL, without stall, give out_valid=1 with that result in cycle c+2.
REQ-027 S2 SHALL advance when empty or out_ready=1; S1 SHALL advance into S2 when S2 advances; in_ready=1 iff S1 empty or S1 advances this cycle.
REQ-028 While out_valid=1 and out_ready=0, result, flag_write and illegal SHALL hold stable; results SHALL leave in acceptance order with none lost or duplicated.
REQ-029 The flag register SHALL update only on an output handshake, only the masked bits, in the same edge.
REQ-030 Simultaneous input and output handshakes with both stages full SHALL be accepted without a bubble.

Reset
REQ-031 rst SHALL immediately clear S1 and S2 valid bits, giving out_valid=0, in_ready=1 (once rst is released), zf=vf=nf=0, flag_write=0, illegal=0, result=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operations, leave flags 0, and produce no output handshake.

Verification
REQ-033 WIDTH=16, ADD 0x7000+0x7000, out_ready=1 -> result 0x7FFF in cycle c+2; after handshake vf=1, nf=0, zf=0.
REQ-034 SUB 0x8000-0x0001 -> 0x8000, vf=1, nf=1; then RED 0x7777,0x7777 -> 0x0038, flag_write=0, flags unchanged.
REQ-035 Preload nf=1 via SUB, then ROR 0x0001 by 1 -> 0x8000, zf=0, nf still 1, vf unchanged.
REQ-036 out_ready=0, drive three back-to-back operations -> two accepted, in_ready=0 on the third; raise out_ready -> three results in order, no bubble.
REQ-037 Both stages full, assert rst for 1 cycle -> out_valid=0 same cycle, flags 0, no stale result after release; opcode 0xC -> result 0, illegal=1.
REQ-038 WIDTH=32: ADD 0x7FFF_FFFF+1 -> 0x7FFF_FFFF, vf=1; SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF.
